axi4_master_read_data_rx: RTL and testbench

- Master-side AXI4 read-data (R channel) receiver: the other end of the slave read-data transmitter.
- After the master's AR handshake it tracks one outstanding burst and accepts R beats with rready.
- Checks rid/rlast/beat count against the issued request; buffers beats in a small FIFO toward the user-side consumer.
- Single outstanding burst only.

---
 rtl/axi4_master_read_data_rx.sv | 207 ++++++++++++++++++++
 tb/tb_axi4_master_read_data_rx.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_master_read_data_rx.sv
// ---------------------------------------------------------------------------
// axi4_master_read_data_rx
//
// Master-side AXI4 R-channel receiver. After the master's AR handshake it
// tracks a single outstanding burst, accepts R beats, checks rid/rlast/beat
// count against the issued request, and buffers beats in a small
// first-word-fall-through FIFO that feeds the user-side consumer.
//
// Optional feature macro: RD_RESP_ACCUM_EN
//   defined   -> burst_resp holds the worst rresp accepted in the burst
//   undefined -> burst_resp is tied to 2'b00
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   ar_fire, ar_id, ar_len   issued read request (AR handshake this cycle)
//   rvalid..rlast, rready    AXI R channel
//   out_valid..out_last      user-side FIFO head, popped by out_ready
//   busy, done, beat_cnt     burst status
//   burst_resp               accumulated burst response
//   err_rid/early/missing    sticky protocol error flags, cleared by err_clr
// ---------------------------------------------------------------------------
module axi4_master_read_data_rx #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ar_fire,
    input  logic [ID_WIDTH-1:0]   ar_id,
    input  logic [7:0]            ar_len,
    input  logic                  rvalid,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [ID_WIDTH-1:0]   rid,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    output logic                  rready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_resp,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [8:0]            beat_cnt,
    output logic [1:0]            burst_resp,
    output logic                  err_rid,
    output logic                  err_early,
    output logic                  err_missing,
    input  logic                  err_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_WIDTH + 3;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RECV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [8:0]          remaining_q, remaining_d;
    logic [8:0]          beat_cnt_q, beat_cnt_d;
    logic                err_rid_q, err_rid_d;
    logic                err_early_q, err_early_d;
    logic                err_missing_q, err_missing_d;

    logic [EW-1:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q;

    logic                accept;
    logic                pop;
    logic                term;
    logic                fifo_full;
    logic [EW-1:0]       head;

    // rready comes only from the registered count, so a pop in the same
    // cycle never opens a slot early.
    assign fifo_full = (count_q == DEPTH_C);
    assign rready    = (state_q == S_RECV) && !fifo_full;
    assign accept    = rvalid && rready;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign term      = rlast || (remaining_q == 9'd1);

    assign head      = mem_q[rd_ptr_q];
    assign out_data  = out_valid ? head[EW-1:3] : '0;
    assign out_resp  = out_valid ? head[2:1]    : 2'b00;
    assign out_last  = out_valid ? head[0]      : 1'b0;

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign beat_cnt    = beat_cnt_q;
    assign err_rid     = err_rid_q;
    assign err_early   = err_early_q;
    assign err_missing = err_missing_q;

    // Burst control: request latch, beat bookkeeping and error checks.
    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        remaining_d   = remaining_q;
        beat_cnt_d    = beat_cnt_q;
        err_rid_d     = err_rid_q;
        err_early_d   = err_early_q;
        err_missing_d = err_missing_q;

        case (state_q)
            S_IDLE: begin
                if (ar_fire) begin
                    id_d        = ar_id;
                    remaining_d = {1'b0, ar_len} + 9'd1;
                    beat_cnt_d  = '0;
                    state_d     = S_RECV;
                end
            end
            S_RECV: begin
                if (accept) begin
                    beat_cnt_d  = beat_cnt_q + 9'd1;
                    remaining_d = remaining_q - 9'd1;
                    if (rid != id_q)
                        err_rid_d = 1'b1;
                    if (rlast && (remaining_q > 9'd1))
                        err_early_d = 1'b1;
                    if (!rlast && (remaining_q == 9'd1))
                        err_missing_d = 1'b1;
                    if (term)
                        state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A clear wins over any flag being set in the same cycle.
        if (err_clr) begin
            err_rid_d     = 1'b0;
            err_early_d   = 1'b0;
            err_missing_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            id_q          <= '0;
            remaining_q   <= '0;
            beat_cnt_q    <= '0;
            err_rid_q     <= 1'b0;
            err_early_q   <= 1'b0;
            err_missing_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            id_q          <= id_d;
            remaining_q   <= remaining_d;
            beat_cnt_q    <= beat_cnt_d;
            err_rid_q     <= err_rid_d;
            err_early_q   <= err_early_d;
            err_missing_q <= err_missing_d;
        end
    end

    // Receive FIFO. Pushes are gated by rready so overflow cannot occur;
    // the stored last bit is the burst terminator, not the raw rlast.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            if (accept) begin
                mem_q[wr_ptr_q] <= {rdata, rresp, term};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (accept && !pop)
                count_q <= count_q + 1'b1;
            else if (!accept && pop)
                count_q <= count_q - 1'b1;
        end
    end

`ifdef RD_RESP_ACCUM_EN
    logic [1:0] burst_resp_q;

    // Response codes are ordered so that a larger value is a worse response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            burst_resp_q <= 2'b00;
        else if ((state_q == S_IDLE) && ar_fire)
            burst_resp_q <= 2'b00;
        else if (accept && (rresp > burst_resp_q))
            burst_resp_q <= rresp;
    end

    assign burst_resp = burst_resp_q;
`else
    assign burst_resp = 2'b00;
`endif

endmodule

// File: tb/tb_axi4_master_read_data_rx.sv
// ---------------------------------------------------------------------------
// tb_axi4_master_read_data_rx
//
// Directed self-checking bench for axi4_master_read_data_rx. All stimulus is
// applied 1 time unit after the rising edge and outputs are observed there.
// Honours RD_RESP_ACCUM_EN for the expected burst_resp value.
// ---------------------------------------------------------------------------
module tb_axi4_master_read_data_rx;

    logic        clk;
    logic        rst;
    logic        ar_fire;
    logic [3:0]  ar_id;
    logic [7:0]  ar_len;
    logic        rvalid;
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_resp;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [8:0]  beat_cnt;
    logic [1:0]  burst_resp;
    logic        err_rid;
    logic        err_early;
    logic        err_missing;
    logic        err_clr;

    int tests;
    int failures;

    axi4_master_read_data_rx #(
        .DATA_WIDTH(32),
        .ID_WIDTH  (4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ar_fire    (ar_fire),
        .ar_id      (ar_id),
        .ar_len     (ar_len),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .rid        (rid),
        .rresp      (rresp),
        .rlast      (rlast),
        .rready     (rready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_resp   (out_resp),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .beat_cnt   (beat_cnt),
        .burst_resp (burst_resp),
        .err_rid    (err_rid),
        .err_early  (err_early),
        .err_missing(err_missing),
        .err_clr    (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_ar(input logic [3:0] id, input logic [7:0] len);
        ar_fire = 1'b1;
        ar_id   = id;
        ar_len  = len;
        step();
        ar_fire = 1'b0;
    endtask

    // Presents one beat and waits (bounded) until it is accepted.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] id,
                             input logic [1:0] resp, input logic last);
        bit got;
        got    = 0;
        rvalid = 1'b1;
        rdata  = d;
        rid    = id;
        rresp  = resp;
        rlast  = last;
        for (int c = 0; c < 20; c++) begin
            if (rready) begin
                step();
                got = 1;
                break;
            end
            step();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        if (!got) begin
            failures++;
            $display("[TB] FAIL beat_accept_timeout data=%h: no rready within 20 cycles", d);
        end
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        tests++;
        if ({rready, out_valid, out_data, out_resp, out_last, busy, done} !== 39'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got rready=%b ov=%b data=%h resp=%b last=%b busy=%b done=%b, want all 0",
                     rready, out_valid, out_data, out_resp, out_last, busy, done);
        end
        tests++;
        if ({beat_cnt, burst_resp, err_rid, err_early, err_missing} !== 14'd0) begin
            failures++;
            $display("[TB] FAIL reset_status: got cnt=%0d bresp=%b errs=%b%b%b, want all 0",
                     beat_cnt, burst_resp, err_rid, err_early, err_missing);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic_burst();
        out_ready = 1'b1;
        issue_ar(4'd5, 8'd3);
        tests++;
        if (busy !== 1'b1 || beat_cnt !== 9'd0) begin
            failures++;
            $display("[TB] FAIL basic_start: busy=%b cnt=%0d, want busy=1 cnt=0", busy, beat_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            send_beat(32'h10 + i, 4'd5, 2'b00, i == 3);
            tests++;
            if (out_valid !== 1'b1 || out_data !== 32'h10 + i || out_last !== (i == 3)) begin
                failures++;
                $display("[TB] FAIL basic_beat%0d: ov=%b data=%h last=%b, want ov=1 data=%h last=%b",
                         i, out_valid, out_data, out_last, 32'h10 + i, i == 3);
            end
        end
        tests++;
        if (done !== 1'b1 || beat_cnt !== 9'd4) begin
            failures++;
            $display("[TB] FAIL basic_done: done=%b cnt=%0d, want done=1 cnt=4", done, beat_cnt);
        end
        step();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_after: done=%b busy=%b ov=%b, want 0 0 0", done, busy, out_valid);
        end
        tests++;
        if ({err_rid, err_early, err_missing} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL basic_errors: got %b%b%b, want 000", err_rid, err_early, err_missing);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        issue_ar(4'd3, 8'd7);
        for (int i = 0; i < 4; i++)
            send_beat(32'h20 + i, 4'd3, 2'b00, 1'b0);
        tests++;
        if (rready !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || out_data !== 32'h20) begin
            failures++;
            $display("[TB] FAIL bp_full: rready=%b busy=%b done=%b head=%h, want 0 1 0 00000020",
                     rready, busy, done, out_data);
        end
        step();
        tests++;
        if (out_data !== 32'h20 || rready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_hold: head=%h rready=%b, want 00000020 0", out_data, rready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== 32'h20 + i) begin
                failures++;
                $display("[TB] FAIL bp_drain%0d: ov=%b data=%h, want 1 %h", i, out_valid, out_data, 32'h20 + i);
            end
            step();
        end
        tests++;
        if (out_valid !== 1'b0 || rready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_empty: ov=%b rready=%b, want 0 1", out_valid, rready);
        end
        for (int i = 4; i < 8; i++)
            send_beat(32'h20 + i, 4'd3, 2'b00, i == 7);
        tests++;
        if (done !== 1'b1 || beat_cnt !== 9'd8 || out_data !== 32'h27 || out_last !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_finish: done=%b cnt=%0d data=%h last=%b, want 1 8 00000027 1",
                     done, beat_cnt, out_data, out_last);
        end
        step();
    endtask

    task automatic test_early_last();
        out_ready = 1'b1;
        issue_ar(4'd1, 8'd7);
        send_beat(32'h30, 4'd1, 2'b00, 1'b0);
        // A second AR while receiving must not reload the burst.
        issue_ar(4'd3, 8'd0);
        tests++;
        if (busy !== 1'b1 || beat_cnt !== 9'd1) begin
            failures++;
            $display("[TB] FAIL ar_ignored: busy=%b cnt=%0d, want 1 1", busy, beat_cnt);
        end
        send_beat(32'h31, 4'd1, 2'b00, 1'b0);
        tests++;
        if (err_missing !== 1'b0 || err_rid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ar_ignored_beat2: missing=%b rid=%b busy=%b, want 0 0 1",
                     err_missing, err_rid, busy);
        end
        send_beat(32'h32, 4'd1, 2'b00, 1'b1);
        tests++;
        if (err_early !== 1'b1 || out_last !== 1'b1 || done !== 1'b1 || beat_cnt !== 9'd3) begin
            failures++;
            $display("[TB] FAIL early_last: early=%b last=%b done=%b cnt=%0d, want 1 1 1 3",
                     err_early, out_last, done, beat_cnt);
        end
        step();
        tests++;
        if (busy !== 1'b0 || err_early !== 1'b1) begin
            failures++;
            $display("[TB] FAIL early_idle: busy=%b early=%b, want 0 1", busy, err_early);
        end
        clear_errors();
    endtask

    task automatic test_missing_last();
        out_ready = 1'b1;
        issue_ar(4'd4, 8'd1);
        send_beat(32'h40, 4'd4, 2'b00, 1'b0);
        send_beat(32'h41, 4'd4, 2'b00, 1'b0);
        tests++;
        if (err_missing !== 1'b1 || err_early !== 1'b0 || beat_cnt !== 9'd2 ||
            out_last !== 1'b1 || out_data !== 32'h41 || done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL missing_last: missing=%b early=%b cnt=%0d last=%b data=%h done=%b, want 1 0 2 1 00000041 1",
                     err_missing, err_early, beat_cnt, out_last, out_data, done);
        end
        clear_errors();
        tests++;
        if (err_missing !== 1'b0) begin
            failures++;
            $display("[TB] FAIL missing_clear: missing=%b, want 0", err_missing);
        end
    endtask

    task automatic test_rid_resp();
        logic [1:0] exp_resp;
`ifdef RD_RESP_ACCUM_EN
        exp_resp = 2'b10;
`else
        exp_resp = 2'b00;
`endif
        out_ready = 1'b1;
        issue_ar(4'd2, 8'd2);
        send_beat(32'h50, 4'd2, 2'b00, 1'b0);
        tests++;
        if (err_rid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rid_good: err_rid=%b, want 0", err_rid);
        end
        send_beat(32'h51, 4'd7, 2'b10, 1'b0);
        tests++;
        if (err_rid !== 1'b1 || out_data !== 32'h51 || out_resp !== 2'b10) begin
            failures++;
            $display("[TB] FAIL rid_bad: err_rid=%b data=%h resp=%b, want 1 00000051 10",
                     err_rid, out_data, out_resp);
        end
        send_beat(32'h52, 4'd2, 2'b01, 1'b1);
        tests++;
        if (done !== 1'b1 || burst_resp !== exp_resp) begin
            failures++;
            $display("[TB] FAIL burst_resp: done=%b bresp=%b, want 1 %b", done, burst_resp, exp_resp);
        end
        step();
        step();
        tests++;
        if (burst_resp !== exp_resp || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL burst_resp_hold: bresp=%b busy=%b, want %b 0", burst_resp, busy, exp_resp);
        end
        clear_errors();
        issue_ar(4'd2, 8'd0);
        tests++;
        if (burst_resp !== 2'b00) begin
            failures++;
            $display("[TB] FAIL burst_resp_clear: bresp=%b, want 00", burst_resp);
        end
        // Clear asserted on the same edge as a mismatching beat.
        err_clr = 1'b1;
        send_beat(32'h53, 4'd9, 2'b00, 1'b1);
        err_clr = 1'b0;
        tests++;
        if (err_rid !== 1'b0 || out_data !== 32'h53) begin
            failures++;
            $display("[TB] FAIL clr_priority: err_rid=%b data=%h, want 0 00000053", err_rid, out_data);
        end
        step();
    endtask

    task automatic test_reset_midburst();
        out_ready = 1'b0;
        issue_ar(4'd6, 8'd3);
        send_beat(32'h60, 4'd6, 2'b00, 1'b0);
        send_beat(32'h61, 4'd6, 2'b00, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (rready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || beat_cnt !== 9'd0) begin
            failures++;
            $display("[TB] FAIL reset_mid: rready=%b ov=%b busy=%b cnt=%0d, want 0 0 0 0",
                     rready, out_valid, busy, beat_cnt);
        end
        step();
        rst = 1'b1;
        step();
        out_ready = 1'b1;
        issue_ar(4'd1, 8'd0);
        tests++;
        if (busy !== 1'b1 || beat_cnt !== 9'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL restart: busy=%b cnt=%0d ov=%b, want 1 0 0", busy, beat_cnt, out_valid);
        end
        send_beat(32'h70, 4'd1, 2'b00, 1'b1);
        tests++;
        if (out_data !== 32'h70 || out_last !== 1'b1 || done !== 1'b1 || beat_cnt !== 9'd1) begin
            failures++;
            $display("[TB] FAIL restart_beat: data=%h last=%b done=%b cnt=%0d, want 00000070 1 1 1",
                     out_data, out_last, done, beat_cnt);
        end
        step();
    endtask

    initial begin
        tests     = 0;
        failures  = 0;
        rst       = 1'b0;
        ar_fire   = 1'b0;
        ar_id     = '0;
        ar_len    = '0;
        rvalid    = 1'b0;
        rdata     = '0;
        rid       = '0;
        rresp     = 2'b00;
        rlast     = 1'b0;
        out_ready = 1'b0;
        err_clr   = 1'b0;

        test_reset();
        test_basic_burst();
        test_backpressure();
        test_early_last();
        test_missing_last();
        test_rid_resp();
        test_reset_midburst();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
